// File: rtl/flash_page_stepper.sv
// Button-driven flash page address stepper with request/ack handoff.
// Optional auto-repeat on held buttons: define FLASH_STEP_AUTO_REPEAT_EN.
module flash_page_stepper #(
  parameter int ADDR_W               = 24,
  parameter int PAGE_BYTES           = 32,
  parameter int DEBOUNCE_CYCLES      = 270000,
  parameter int REPEAT_DELAY_CYCLES  = 13500000,
  parameter int REPEAT_PERIOD_CYCLES = 2700000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_btn1,
  input  logic              i_btn2,
  input  logic              i_ack,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_busy
);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PAGE = ADDR_W'(PAGE_BYTES);

  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    lvl;
  logic [DW-1:0] db_cnt [2];
  logic [1:0]    press;
  logic [1:0]    ev;

  state_t            state;
  logic              pend;
  logic [ADDR_W-1:0] nxt;
  logic              step;
  logic              launch;
  logic [ADDR_W-1:0] nxt_step;

  // Index 0 steps forward, index 1 steps backward.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_a <= 2'b11;
      sync_b <= 2'b11;
      lvl    <= 2'b11;
      for (int b = 0; b < 2; b++) db_cnt[b] <= '0;
    end else begin
      sync_a <= {i_btn2, i_btn1};
      sync_b <= sync_a;
      for (int b = 0; b < 2; b++) begin
        if (sync_b[b] == lvl[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          lvl[b]    <= sync_b[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press = '0;
    for (int b = 0; b < 2; b++)
      press[b] = lvl[b] & ~sync_b[b] & (db_cnt[b] == DB_LAST);
  end

`ifdef FLASH_STEP_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY_CYCLES + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RPT_RELOAD =
    RW'(REPEAT_DELAY_CYCLES - REPEAT_PERIOD_CYCLES);

  logic [RW-1:0] rpt_cnt [2];
  logic [1:0]    rpt_fire;

  always_comb begin
    rpt_fire = '0;
    for (int b = 0; b < 2; b++)
      rpt_fire[b] = ~lvl[b] & (rpt_cnt[b] == RPT_LAST);
  end

  // Counter starts the cycle after the press event; reload spaces repeats.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < 2; b++) rpt_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (lvl[b])
          rpt_cnt[b] <= '0;
        else if (rpt_fire[b])
          rpt_cnt[b] <= RPT_RELOAD;
        else
          rpt_cnt[b] <= rpt_cnt[b] + 1'b1;
      end
    end
  end

  assign ev = press | rpt_fire;
`else
  logic unused_rpt;
  assign unused_rpt = ^{REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES};
  assign ev = press;
`endif

  assign step     = ev[0] ^ ev[1];
  assign nxt_step = ev[0] ? nxt + PAGE : nxt - PAGE;
  assign launch   = (state == IDLE) & pend;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      o_req  <= 1'b0;
      o_addr <= '0;
      nxt    <= '0;
      pend   <= 1'b1;
    end else begin
      if (step) nxt <= nxt_step;
      pend <= step | (pend & ~launch);
      unique case (state)
        IDLE: begin
          if (pend) begin
            o_addr <= nxt;
            o_req  <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (i_ack) begin
            o_req <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign o_busy = o_req | pend;

endmodule
